// File: rtl/common.sv
// Shared types for the memory access unit: access kinds, FSM states and
// small classification helpers that never rely on enum encodings.
package common;

  typedef enum logic [3:0] {
    NONE, LB, LH, LW, LBU, LHU, SB, SH, SW
  } mem_access_type;

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, RESP
  } mau_state_t;

  function automatic logic is_load(input mem_access_type t);
    return t inside {LB, LH, LW, LBU, LHU};
  endfunction

  function automatic logic is_store(input mem_access_type t);
    return t inside {SB, SH, SW};
  endfunction

  function automatic logic is_misaligned(input mem_access_type t, input logic [1:0] a);
    case (t)
      LH, LHU, SH: return a[0];
      LW, SW:      return (a != 2'b00);
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the byte/half lane addressed by the low address bits out of a bus
// word and sign- or zero-extends it according to the load kind.
module load_extend
  import common::*;
(
  input  mem_access_type access_type,
  input  logic [1:0]     addr,
  input  logic [31:0]    rdata,
  output logic [31:0]    ext_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (addr)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    w_half = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (access_type)
      LB:      ext_data = {{24{w_byte[7]}}, w_byte};
      LBU:     ext_data = {24'h0, w_byte};
      LH:      ext_data = {{16{w_half[15]}}, w_half};
      LHU:     ext_data = {16'h0, w_half};
      LW:      ext_data = rdata;
      default: ext_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit between the execute stage and a simple
// request/grant/rvalid bus; faults and NONE requests complete without bus traffic.
module mem_access_unit
  import common::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  mem_access_type access_type,
  input  logic [31:0]    addr,
  input  logic [31:0]    wdata,
  input  logic [4:0]     rd,
  output logic           resp_valid,
  output logic [31:0]    resp_rdata,
  output logic [4:0]     resp_rd,
  output logic           misaligned,
  output logic           bus_req,
  output logic           bus_we,
  output logic [31:0]    bus_addr,
  output logic [3:0]     bus_wstrb,
  output logic [31:0]    bus_wdata,
  input  logic           bus_gnt,
  input  logic           bus_rvalid,
  input  logic [31:0]    bus_rdata
);

  mau_state_t     r_state, w_next;
  mem_access_type r_type;
  logic [31:0]    r_addr, r_wdata, r_rdata;
  logic [4:0]     r_rd;
  logic           r_mis;
  logic [31:0]    w_ext;
  logic           w_accept;

  assign w_accept = req_valid && (r_state == IDLE);

  load_extend u_load_extend (
    .access_type (r_type),
    .addr        (r_addr[1:0]),
    .rdata       (bus_rdata),
    .ext_data    (w_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_type  <= NONE;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
      r_rd    <= 5'h0;
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_type  <= access_type;
        r_addr  <= addr;
        r_wdata <= wdata;
        r_rd    <= rd;
        r_mis   <= is_misaligned(access_type, addr[1:0]);
        r_rdata <= 32'h0;
      end else if (r_state == WAIT && bus_rvalid) begin
        r_rdata <= w_ext;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'h0;
    resp_rd    = 5'h0;
    misaligned = 1'b0;
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = 32'h0;
    bus_wstrb  = 4'h0;
    bus_wdata  = 32'h0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if ((is_load(access_type) || is_store(access_type)) &&
              !is_misaligned(access_type, addr[1:0]))
            w_next = REQ;
          else
            w_next = RESP;
        end
      end
      REQ: begin
        bus_req  = 1'b1;
        bus_addr = {r_addr[31:2], 2'b00};
        if (is_store(r_type)) begin
          bus_we = 1'b1;
          case (r_type)
            SB: begin
              bus_wstrb = 4'b0001 << r_addr[1:0];
              bus_wdata = {4{r_wdata[7:0]}};
            end
            SH: begin
              bus_wstrb = 4'b0011 << {r_addr[1], 1'b0};
              bus_wdata = {2{r_wdata[15:0]}};
            end
            default: begin
              bus_wstrb = 4'b1111;
              bus_wdata = r_wdata;
            end
          endcase
        end
        // rvalid in the grant cycle belongs to nobody; loads always pass through WAIT
        if (bus_gnt)
          w_next = is_store(r_type) ? RESP : WAIT;
      end
      WAIT: begin
        if (bus_rvalid)
          w_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = r_rdata;
        resp_rd    = r_rd;
        misaligned = r_mis;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized checks of mem_access_unit against an arithmetic
// reference model of access sizes, lanes, strobes and extension.
module tb_mem_access_unit;
  import common::*;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  mem_access_type access_type = NONE;
  logic [31:0]    addr = 32'h0;
  logic [31:0]    wdata = 32'h0;
  logic [4:0]     rd = 5'h0;
  logic           resp_valid;
  logic [31:0]    resp_rdata;
  logic [4:0]     resp_rd;
  logic           misaligned;
  logic           bus_req;
  logic           bus_we;
  logic [31:0]    bus_addr;
  logic [3:0]     bus_wstrb;
  logic [31:0]    bus_wdata;
  logic           bus_gnt = 1'b0;
  logic           bus_rvalid = 1'b0;
  logic [31:0]    bus_rdata = 32'h0;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .access_type (access_type),
    .addr        (addr),
    .wdata       (wdata),
    .rd          (rd),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_rd     (resp_rd),
    .misaligned  (misaligned),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wstrb   (bus_wstrb),
    .bus_wdata   (bus_wdata),
    .bus_gnt     (bus_gnt),
    .bus_rvalid  (bus_rvalid),
    .bus_rdata   (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes, 0 for NONE
  function automatic int size_of(input mem_access_type t);
    case (t)
      LB, LBU, SB: return 1;
      LH, LHU, SH: return 2;
      LW, SW:      return 4;
      default:     return 0;
    endcase
  endfunction

  function automatic logic [3:0] exp_strb(input mem_access_type t, input logic [31:0] a);
    int m;
    m = (1 << size_of(t)) - 1;
    return 4'(m << int'(a % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input mem_access_type t, input logic [31:0] d);
    case (t)
      SB:      return {24'h0, d[7:0]} * 32'h0101_0101;
      SH:      return {16'h0, d[15:0]} * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input mem_access_type t, input logic [31:0] a,
                                           input logic [31:0] d);
    logic [31:0] s;
    s = d >> (8 * (a % 4));
    case (t)
      LB:      return s[7]  ? (s & 32'hFF)   - 32'h100   : (s & 32'hFF);
      LBU:     return s & 32'hFF;
      LH:      return s[15] ? (s & 32'hFFFF) - 32'h10000 : (s & 32'hFFFF);
      LHU:     return s & 32'hFFFF;
      default: return d;
    endcase
  endfunction

  // Runs one request from an IDLE sample point back to the next IDLE sample point
  task automatic do_txn(input mem_access_type t, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdat, input int gd, input int rvd, input logic noise);
    logic [4:0] tag;
    int         sz;
    logic       legal;
    logic       st;
    tag   = 5'($urandom);
    sz    = size_of(t);
    legal = 1'b0;
    if (sz != 0) legal = ((a % sz) == 0);
    st    = (t == SB) || (t == SH) || (t == SW);

    check1("idle_ready", req_ready, 1'b1);
    req_valid = 1'b1; access_type = t; addr = a; wdata = wd; rd = tag;
    @(posedge clk); #1;
    req_valid = 1'b0;
    access_type = mem_access_type'($urandom_range(0, 8));
    addr = $urandom; wdata = $urandom; rd = 5'($urandom);

    if (!legal) begin
      check1("fast_bus_req", bus_req, 1'b0);
      check1("fast_resp_valid", resp_valid, 1'b1);
      check1("fast_misaligned", misaligned, sz != 0);
      check32("fast_rdata", resp_rdata, 32'h0);
      check32("fast_rd", {27'h0, resp_rd}, {27'h0, tag});
    end else begin
      for (int i = 0; i <= gd; i++) begin
        check1("req_bus_req", bus_req, 1'b1);
        check32("req_addr", bus_addr, a & ~32'h3);
        check1("req_we", bus_we, st);
        if (st) begin
          check32("req_wstrb", {28'h0, bus_wstrb}, {28'h0, exp_strb(t, a)});
          check32("req_wdata", bus_wdata, exp_wdata(t, wd));
        end
        check1("req_ready_low", req_ready, 1'b0);
        check1("req_no_resp", resp_valid, 1'b0);
        bus_gnt = (i == gd); bus_rvalid = noise; bus_rdata = $urandom;
        @(posedge clk); #1;
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
      end
      if (!st) begin
        for (int i = 0; i <= rvd; i++) begin
          check1("wait_bus_req", bus_req, 1'b0);
          check1("wait_no_resp", resp_valid, 1'b0);
          check1("wait_ready_low", req_ready, 1'b0);
          bus_rvalid = (i == rvd);
          bus_rdata  = (i == rvd) ? rdat : $urandom;
          @(posedge clk); #1;
          bus_rvalid = 1'b0; bus_rdata = $urandom;
        end
      end
      check1("resp_valid", resp_valid, 1'b1);
      check32("resp_rdata", resp_rdata, st ? 32'h0 : exp_load(t, a, rdat));
      check1("resp_misaligned", misaligned, 1'b0);
      check32("resp_rd", {27'h0, resp_rd}, {27'h0, tag});
      check1("resp_bus_idle", bus_req, 1'b0);
    end
    @(posedge clk); #1;
    check1("resp_one_cycle", resp_valid, 1'b0);
    check1("back_idle", req_ready, 1'b1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check1("rst_req_ready", req_ready, 1'b1);
    check1("rst_resp_valid", resp_valid, 1'b0);
    check32("rst_resp_rdata", resp_rdata, 32'h0);
    check32("rst_resp_rd", {27'h0, resp_rd}, 32'h0);
    check1("rst_misaligned", misaligned, 1'b0);
    check1("rst_bus_req", bus_req, 1'b0);
    check1("rst_bus_we", bus_we, 1'b0);
    check32("rst_bus_addr", bus_addr, 32'h0);
    check32("rst_bus_wstrb", {28'h0, bus_wstrb}, 32'h0);
    check32("rst_bus_wdata", bus_wdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed scenarios
    check32("dir_lb_model", exp_load(LB, 32'h1003, 32'h80FF_0000), 32'hFFFF_FF80);
    do_txn(LB,   32'h0000_1003, 32'h0,         32'h80FF_0000, 0, 0, 1'b0);
    do_txn(LHU,  32'h0000_2002, 32'h0,         32'hBEEF_1234, 0, 0, 1'b1);
    do_txn(SB,   32'h0000_3001, 32'h0000_00AB, 32'h0,         0, 0, 1'b0);
    do_txn(LW,   32'h0000_4002, 32'h0,         32'h0,         0, 0, 1'b0);
    do_txn(SW,   32'h0000_5008, 32'h1234_5678, 32'h0,         3, 0, 1'b1);
    do_txn(NONE, 32'h0000_6001, 32'hFFFF_FFFF, 32'h0,         0, 0, 1'b0);
    do_txn(SH,   32'h0000_7002, 32'h0000_CAFE, 32'h0,         1, 0, 1'b0);
    do_txn(LH,   32'h0000_7002, 32'h0,         32'h8001_7FFF, 2, 2, 1'b1);

    // Reset while a load sits in WAIT
    req_valid = 1'b1; access_type = LW; addr = 32'h0000_8000; rd = 5'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    check1("abort_in_wait", bus_req, 1'b0);
    check1("abort_wait_busy", req_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check1("abort_rst_ready", req_ready, 1'b1);
    check1("abort_rst_bus_req", bus_req, 1'b0);
    check1("abort_rst_resp", resp_valid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    check1("abort_no_resp_1", resp_valid, 1'b0);
    check1("abort_idle_1", req_ready, 1'b1);
    @(posedge clk); #1;
    check1("abort_no_resp_2", resp_valid, 1'b0);
    do_txn(LW, 32'h0000_9004, 32'h0, 32'hA5A5_5A5A, 0, 1, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      do_txn(mem_access_type'($urandom_range(0, 8)), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have exactly one clock and one reset: clk, the single clock, and rst_n, an asynchronous active-low reset.
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request from execute stage
- req_ready  out  1  unit can accept a request
- access_type  in  4  common::mem_access_type (NONE, LB, LH, LW, LBU, LHU, SB, SH, SW)
- addr  in  32  effective byte address (ALU ADD result)
- wdata  in  32  store data (rs2 value)
- rd  in  5  destination register tag
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores, NONE and faults
- resp_rd  out  5  tag of the completed request
- misaligned  out  1  fault flag, valid with resp_valid
- bus_req  out  1  bus request
- bus_we  out  1  1 = write
- bus_addr  out  32  word-aligned address {addr[31:2],2'b00}
- bus_wstrb  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_gnt  in  1  bus accepts request in this cycle
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read word

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, REQ, WAIT and RESP.
REQ-004 req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted when req_valid && req_ready; at acceptance the block SHALL register access_type, addr, wdata and rd.
REQ-005 A NONE request SHALL go IDLE->RESP with no bus activity and misaligned=0.
REQ-006 A misaligned request (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) SHALL go IDLE->RESP with no bus activity and misaligned=1.
REQ-007 A legal load or store SHALL go IDLE->REQ, and in REQ the block SHALL hold bus_req=1 with bus_addr, bus_we, bus_wstrb and bus_wdata stable until bus_gnt=1.
REQ-008 In REQ with bus_gnt=1, a store SHALL go to RESP and a load SHALL go to WAIT.
REQ-009 In WAIT, a load SHALL stay until bus_rvalid=1, then SHALL capture bus_rdata and go to RESP.
REQ-010 bus_rvalid outside WAIT SHALL be ignored.
REQ-011 In RESP, resp_valid SHALL be 1 for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-012 Minimum load latency SHALL be 3 cycles from acceptance to resp_valid (gnt in first REQ cycle, rvalid in first WAIT cycle); minimum store latency SHALL be 2 cycles.
REQ-013 Store encoding SHALL be:
- SB: wstrb=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}
- SH: wstrb=4'b0011<<{addr[1],1'b0}, wdata={2{wdata[15:0]}}
- SW: wstrb=4'b1111
REQ-014 Load extraction SHALL select the byte/half lane by addr[1:0]; LB/LH SHALL sign-extend to 32 bits and LBU/LHU SHALL zero-extend.
REQ-015 When not in REQ, bus_req SHALL be 0, and bus_we, bus_wstrb and bus_wdata SHALL be 0.
REQ-016 If bus_gnt and bus_rvalid are asserted in the same REQ cycle, bus_rvalid SHALL be ignored and the load SHALL wait in WAIT for a later bus_rvalid.

Reset
REQ-017 While rst_n=0, the FSM SHALL be IDLE, all outputs SHALL be 0 except req_ready=1, and all registered fields SHALL be 0.
REQ-018 Reset mid-transaction SHALL abandon the bus access immediately, with no resp_valid issued for it.

Structure
REQ-019 The FSM state typedef SHALL live in package common, next to mem_access_type.
REQ-020 The block SHALL NOT depend on numeric enum encodings.
REQ-021 Combinational load lane selection/extension SHALL be a sub-module named load_extend (inputs access_type, addr[1:0], rdata; output 32-bit value).

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- LB, addr=0x1003, bus_rdata=0x80FF_0000 -> resp_rdata=0xFFFF_FF80, bus_addr=0x1000, misaligned=0
- LHU, addr=0x2002, bus_rdata=0xBEEF_1234 -> resp_rdata=0x0000_BEEF
- SB, addr=0x3001, wdata=0x0000_00AB -> bus_wstrb=4'b0010, bus_wdata=0xABAB_ABAB, bus_we=1; resp_valid 2 cycles after acceptance when gnt is immediate
- LW, addr=0x4002 -> no bus_req, resp_valid next cycle, misaligned=1, resp_rdata=0
- SW with bus_gnt delayed 3 cycles -> bus_req/bus_addr held stable for 4 cycles, req_ready=0 throughout
- rst_n pulled low while in WAIT -> IDLE, bus_req=0, no resp_valid; a following LW completes normally
